// File: rtl/acorn_pkg.sv
// Shared constants, state encoding and step-to-state decode for the ACORN-128 decryption control block.
package acorn_pkg;

    localparam int CNT_W = 12;

    localparam logic [CNT_W-1:0] MSG_START = 12'd384;
    localparam logic [CNT_W-1:0] MSG_LEN   = 12'd128;
    localparam logic [CNT_W-1:0] CA_END    = 12'd639;
    localparam logic [CNT_W-1:0] TAG_START = 12'd1152;
    localparam logic [CNT_W-1:0] TAG_LEN   = 12'd128;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DEC   = 3'd1,
        PAD   = 3'd2,
        ZERO  = 3'd3,
        FINAL = 3'd4
    } state_e;

    function automatic state_e step_state(input logic [CNT_W-1:0] cnt);
        state_e st;
        if (cnt < MSG_START) begin
            st = IDLE;
        end else if (cnt < (MSG_START + MSG_LEN)) begin
            st = DEC;
        end else if (cnt == (MSG_START + MSG_LEN)) begin
            st = PAD;
        end else if (cnt <= CA_END) begin
            st = ZERO;
        end else begin
            st = FINAL;
        end
        return st;
    endfunction

endpackage

// File: rtl/acorn_tag_check.sv
// Collects the keystream MSB first over the tag window and compares it with the expected tag.
module acorn_tag_check
    import acorn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_ep,
    input  logic             ks_in,
    input  logic [127:0]     tag_in,
    output logic             tag_ok,
    output logic             tag_done
);

    logic [127:0] coll_q, coll_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         run_q, run_d;
    logic         complete_q, complete_d;
    logic         ok_q, ok_d;
    logic         done_q, done_d;
    logic [6:0]   tag_off_s;
    logic         in_win_s;

    // Collection run tracking and compare/hold of the result flags.
    always_comb begin
        tag_off_s  = 7'(count_ep - TAG_START);
        in_win_s   = (count_ep >= TAG_START) && (count_ep < (TAG_START + TAG_LEN));
        coll_d     = coll_q;
        cnt_d      = cnt_q;
        run_d      = 1'b0;
        complete_d = 1'b0;
        ok_d       = ok_q;
        done_d     = done_q;
        if (in_win_s) begin
            coll_d = {coll_q[126:0], ks_in};
            if (count_ep == TAG_START) begin
                cnt_d = 8'd1;
                run_d = 1'b1;
            end else if (run_q && ({1'b0, tag_off_s} == cnt_q)) begin
                cnt_d = cnt_q + 8'd1;
                run_d = 1'b1;
            end else begin
                cnt_d = cnt_q;
                run_d = 1'b0;
            end
            complete_d = run_d && (cnt_d == 8'd128);
        end else begin
            run_d      = 1'b0;
            complete_d = 1'b0;
        end
        if (count_ep < MSG_START) begin
            ok_d   = 1'b0;
            done_d = 1'b0;
        end else if (complete_q) begin
            ok_d   = (coll_q == tag_in);
            done_d = 1'b1;
        end else begin
            ok_d   = ok_q;
            done_d = done_q;
        end
    end

    // Tag state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q     <= 128'd0;
            cnt_q      <= 8'd0;
            run_q      <= 1'b0;
            complete_q <= 1'b0;
            ok_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            coll_q     <= coll_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            complete_q <= complete_d;
            ok_q       <= ok_d;
            done_q     <= done_d;
        end
    end

    assign tag_ok   = ok_q;
    assign tag_done = done_q;

endmodule

// File: rtl/acorn_decryption.sv
// ACORN-128 decryption control/data block: ca/cb control, plaintext recovery and assembly.
// Optional tag check is built only when ACORN_DEC_TAG_EN is defined.
module acorn_decryption
    import acorn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_ep,
    input  logic [127:0]     ciphertext_in,
    input  logic             ks_in,
    output logic             ca_out,
    output logic             cb_out,
    output logic             mbit_out,
    output logic [127:0]     plaintext_out,
    output logic             pt_valid,
    output logic             busy,
    input  logic [127:0]     tag_in,
    output logic             tag_ok,
    output logic             tag_done
);

    state_e       state_q, state_d;
    logic [127:0] pt_sr_q, pt_sr_d;
    logic [127:0] plaintext_q, plaintext_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic         run_q, run_d;
    logic         ca_q, ca_d;
    logic         cb_q, cb_d;
    logic         mbit_q, mbit_d;
    logic         ptv_q, ptv_d;
    logic         busy_q, busy_d;
    logic [6:0]   dec_off_s;
    logic         rec_bit_s;

    // Next-state decode, bit recovery and plaintext assembly.
    always_comb begin
        state_d     = step_state(count_ep);
        dec_off_s   = 7'(count_ep - MSG_START);
        rec_bit_s   = ciphertext_in[7'd127 - dec_off_s] ^ ks_in;
        pt_sr_d     = pt_sr_q;
        plaintext_d = plaintext_q;
        bit_cnt_d   = bit_cnt_q;
        run_d       = 1'b0;
        mbit_d      = 1'b0;
        ptv_d       = 1'b0;
        ca_d        = (count_ep <= CA_END);
        cb_d        = 1'b0;
        busy_d      = (state_d == DEC) || (state_d == PAD) || (state_d == ZERO);
        case (state_d)
            DEC: begin
                mbit_d  = rec_bit_s;
                pt_sr_d = {pt_sr_q[126:0], rec_bit_s};
                // A run stays alive only while each step is exactly the next expected index.
                if (count_ep == MSG_START) begin
                    bit_cnt_d = 8'd1;
                    run_d     = 1'b1;
                end else if (run_q && ({1'b0, dec_off_s} == bit_cnt_q)) begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    run_d     = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q;
                    run_d     = 1'b0;
                end
            end
            PAD: begin
                mbit_d = 1'b1;
                if (run_q && (bit_cnt_q == 8'd128)) begin
                    ptv_d       = 1'b1;
                    plaintext_d = pt_sr_q;
                end else begin
                    ptv_d       = 1'b0;
                    plaintext_d = plaintext_q;
                end
            end
            default: begin
                mbit_d = 1'b0;
                run_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pt_sr_q     <= 128'd0;
            plaintext_q <= 128'd0;
            bit_cnt_q   <= 8'd0;
            run_q       <= 1'b0;
            ca_q        <= 1'b0;
            cb_q        <= 1'b0;
            mbit_q      <= 1'b0;
            ptv_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pt_sr_q     <= pt_sr_d;
            plaintext_q <= plaintext_d;
            bit_cnt_q   <= bit_cnt_d;
            run_q       <= run_d;
            ca_q        <= ca_d;
            cb_q        <= cb_d;
            mbit_q      <= mbit_d;
            ptv_q       <= ptv_d;
            busy_q      <= busy_d;
        end
    end

    assign ca_out        = ca_q;
    assign cb_out        = cb_q;
    assign mbit_out      = mbit_q;
    assign plaintext_out = plaintext_q;
    assign pt_valid      = ptv_q;
    assign busy          = busy_q;

`ifdef ACORN_DEC_TAG_EN
    acorn_tag_check u_tag_check (
        .clk      (clk),
        .rst      (rst),
        .count_ep (count_ep),
        .ks_in    (ks_in),
        .tag_in   (tag_in),
        .tag_ok   (tag_ok),
        .tag_done (tag_done)
    );
`else
    logic tag_unused_s;
    assign tag_unused_s = ^{tag_in, state_q};
    assign tag_ok       = 1'b0;
    assign tag_done     = 1'b0;
`endif

endmodule

// File: tb/tb_acorn_decryption.sv
// Scoreboard bench for acorn_decryption: a step-level reference model predicts every registered output.
module tb_acorn_decryption;
    import acorn_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] count_ep;
    logic [127:0]     ciphertext_in;
    logic             ks_in;
    logic             ca_out, cb_out, mbit_out, pt_valid, busy, tag_ok, tag_done;
    logic [127:0]     plaintext_out;
    logic [127:0]     tag_in;

    always #5 clk = ~clk;

    acorn_decryption dut (
        .clk           (clk),
        .rst           (rst),
        .count_ep      (count_ep),
        .ciphertext_in (ciphertext_in),
        .ks_in         (ks_in),
        .ca_out        (ca_out),
        .cb_out        (cb_out),
        .mbit_out      (mbit_out),
        .plaintext_out (plaintext_out),
        .pt_valid      (pt_valid),
        .busy          (busy),
        .tag_in        (tag_in),
        .tag_ok        (tag_ok),
        .tag_done      (tag_done)
    );

    typedef struct {
        int           c;
        logic         ca, cb, mbit, ptv, busy, tok, tdone;
        logic [127:0] pt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   pulse_at  = -1;
    int   mbit_ones = 0;

    int           ks_mode  = 0;
    logic         ks_const = 1'b0;
    logic [127:0] ks_pat   = 128'd0;
    logic [127:0] cfg_ct   = 128'd0;
    logic [127:0] cfg_tag  = 128'd0;

    // Reference model state: recovered bits as a list plus the index expected next.
    logic         m_rec[$];
    int           m_next = -1;
    logic [127:0] m_pt   = 128'd0;
    logic         m_tb[$];
    int           m_tnext = -1;
    logic         m_tpend = 1'b0;
    logic [127:0] m_tcoll = 128'd0;
    logic         m_tdone = 1'b0;
    logic         m_tok   = 1'b0;

    function automatic logic [127:0] pack_msb_first(input logic q[$]);
        logic [127:0] v = 128'd0;
        for (int i = 0; i < 128; i++) v[127-i] = q[i];
        return v;
    endfunction

    task automatic model_step(input int c, input logic r, input logic [127:0] ct,
                              input logic ks, input logic [127:0] tg, output exp_t e);
        logic b;
        e.c = c;
        if (r) begin
            m_rec.delete(); m_next = -1; m_pt = 128'd0;
            m_tb.delete(); m_tnext = -1; m_tpend = 1'b0; m_tdone = 1'b0; m_tok = 1'b0;
            e.ca = 1'b0; e.cb = 1'b0; e.mbit = 1'b0; e.ptv = 1'b0; e.busy = 1'b0;
        end else begin
            e.ca   = (c <= 639);
            e.cb   = 1'b0;
            e.busy = (c >= 384) && (c <= 639);
            e.ptv  = 1'b0;
            e.mbit = (c == 512);
            if (c >= 384 && c < 512) begin
                b      = ct[511-c] ^ ks;
                e.mbit = b;
                if (c == 384) begin
                    m_rec.delete(); m_rec.push_back(b); m_next = 385;
                end else if (c == m_next) begin
                    m_rec.push_back(b); m_next++;
                end else begin
                    m_rec.delete(); m_next = -1;
                end
            end else begin
                if (c == 512 && m_next == 512 && m_rec.size() == 128) begin
                    e.ptv = 1'b1;
                    m_pt  = pack_msb_first(m_rec);
                end
                m_rec.delete(); m_next = -1;
            end
            if (c < 384) begin
                m_tdone = 1'b0; m_tok = 1'b0; m_tpend = 1'b0;
            end else if (m_tpend) begin
                m_tdone = 1'b1; m_tok = (m_tcoll == tg); m_tpend = 1'b0;
            end
            if (c == 1152) begin
                m_tb.delete(); m_tb.push_back(ks); m_tnext = 1153;
            end else if (c > 1152 && c < 1280 && c == m_tnext) begin
                m_tb.push_back(ks); m_tnext++;
                if (m_tb.size() == 128) begin
                    m_tcoll = pack_msb_first(m_tb);
                    m_tpend = 1'b1;
                end
            end else begin
                m_tb.delete(); m_tnext = -1;
            end
        end
        e.pt = m_pt;
`ifdef ACORN_DEC_TAG_EN
        e.tdone = m_tdone;
        e.tok   = m_tok;
`else
        e.tdone = 1'b0;
        e.tok   = 1'b0;
`endif
    endtask

    task automatic drive(input int c, input logic r);
        exp_t e;
        logic ks_v;
        @(negedge clk);
        case (ks_mode)
            0:       ks_v = ks_const;
            1:       ks_v = 1'($urandom);
            default: ks_v = (c >= 1152 && c < 1280) ? ks_pat[1279-c] : 1'($urandom);
        endcase
        rst           = r;
        count_ep      = 12'(c);
        ciphertext_in = cfg_ct;
        tag_in        = cfg_tag;
        ks_in         = ks_v;
        model_step(c, r, cfg_ct, ks_v, cfg_tag, e);
        exp_q.push_back(e);
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) drive(c, 1'b0);
    endtask

    task automatic flush();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    // Monitor: pops one prediction per cycle and compares all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ca_out !== e.ca || cb_out !== e.cb || mbit_out !== e.mbit || pt_valid !== e.ptv ||
                    busy !== e.busy || tag_ok !== e.tok || tag_done !== e.tdone || plaintext_out !== e.pt) begin
                    errors++;
                    $display("FAIL outputs step=%0d got ca=%b cb=%b mbit=%b ptv=%b busy=%b tok=%b tdone=%b pt=%h want ca=%b cb=%b mbit=%b ptv=%b busy=%b tok=%b tdone=%b pt=%h",
                             e.c, ca_out, cb_out, mbit_out, pt_valid, busy, tag_ok, tag_done, plaintext_out,
                             e.ca, e.cb, e.mbit, e.ptv, e.busy, e.tok, e.tdone, e.pt);
                end
                if (pt_valid === 1'b1) begin
                    pulse_cnt++;
                    pulse_at = e.c;
                end
                if (mbit_out === 1'b1) mbit_ones++;
            end
        end
    end

    initial begin
        logic [127:0] prev_pt;
        logic [127:0] ref_ct;
        rst = 1'b1; count_ep = '0; ciphertext_in = '0; ks_in = 1'b0; tag_in = '0;

        for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, 4095)), 1'b1);

        // All-zero ciphertext against an all-one keystream.
        cfg_ct = 128'd0; ks_mode = 0; ks_const = 1'b1;
        pulse_cnt = 0; mbit_ones = 0;
        sweep(0, 700);
        flush();
        chk("pt_all_ones", plaintext_out, {128{1'b1}});
        chk("pulse_count_t1", 128'(pulse_cnt), 128'd1);
        chk("pulse_step_t1", 128'(pulse_at), 128'd512);
        chk("mbit_ones_t1", 128'(mbit_ones), 128'd129);

        // Only the end bits set, zero keystream: mbit at 384, 511 and the pad step.
        cfg_ct = {1'b1, 126'd0, 1'b1}; ks_const = 1'b0;
        mbit_ones = 0;
        sweep(0, 700);
        flush();
        chk("pt_end_bits", plaintext_out, {1'b1, 126'd0, 1'b1});
        chk("mbit_ones_t2", 128'(mbit_ones), 128'd3);

        // Random blocks with a random keystream.
        ks_mode = 1;
        for (int k = 0; k < 3; k++) begin
            cfg_ct = {$urandom, $urandom, $urandom, $urandom};
            sweep(0, 520);
        end

        // Abort mid-window: no pulse, old plaintext held, busy drops.
        prev_pt = m_pt;
        cfg_ct = {$urandom, $urandom, $urandom, $urandom};
        pulse_cnt = 0;
        sweep(0, 450);
        sweep(0, 20);
        flush();
        chk("abort_no_pulse", 128'(pulse_cnt), 128'd0);
        chk("abort_pt_held", plaintext_out, prev_pt);
        chk("abort_busy", 128'(busy), 128'd0);

        // Repeated and skipped steps inside the window.
        sweep(0, 400); drive(400, 1'b0); sweep(401, 520);
        sweep(0, 449); sweep(451, 520);
        flush();
        chk("noncontig_no_pulse", 128'(pulse_cnt), 128'd0);

        // Reset mid-window, then a clean restart with zero keystream.
        sweep(0, 499);
        drive(500, 1'b1);
        flush();
        chk("rst_pt_zero", plaintext_out, 128'd0);
        chk("rst_ctrl_zero", 128'({ca_out, cb_out, mbit_out, pt_valid, busy}), 128'd0);
        ref_ct = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        cfg_ct = ref_ct; ks_mode = 0; ks_const = 1'b0;
        pulse_cnt = 0;
        sweep(0, 520);
        flush();
        chk("restart_pt", plaintext_out, ref_ct);
        chk("restart_pulse", 128'(pulse_cnt), 128'd1);

        // Tag window with matching and single-bit-flipped expected tags.
        ks_mode = 2; ks_pat = {16{8'hA5}}; cfg_tag = ks_pat;
        sweep(0, 1282);
        flush();
`ifdef ACORN_DEC_TAG_EN
        chk("tag_match", 128'({tag_done, tag_ok}), 128'd3);
`else
        chk("tag_tied", 128'({tag_done, tag_ok}), 128'd0);
`endif
        cfg_tag = ks_pat ^ (128'd1 << 37);
        sweep(0, 1282);
        flush();
`ifdef ACORN_DEC_TAG_EN
        chk("tag_mismatch", 128'({tag_done, tag_ok}), 128'd2);
`else
        chk("tag_tied2", 128'({tag_done, tag_ok}), 128'd0);
`endif
        sweep(0, 5);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
